// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: elastic valid/ready pipeline register; define PIPE_STAGE_SKID_EN for a skid buffer.
module pipe_stage_reg #(
  parameter int WIDTH  = 32,
  parameter int FIELDS = 5
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [FIELDS*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [FIELDS*WIDTH-1:0] out_data,
  output logic [1:0]              occupancy
);
  localparam int BW = FIELDS * WIDTH;
  logic [1:0]    occ_q, occ_d;
  logic [BW-1:0] main_q, main_d;
  logic          accept, emit;
  assign out_valid = occ_q != 2'd0;
  assign out_data  = main_q;
  assign occupancy = occ_q;
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;
`ifdef PIPE_STAGE_SKID_EN
  logic [BW-1:0] skid_q, skid_d;
  assign in_ready = occ_q != 2'd2;
  always_comb begin
    occ_d  = occ_q;
    main_d = main_q;
    skid_d = skid_q;
    case (occ_q)
      2'd0: begin
        occ_d  = accept ? 2'd1 : 2'd0;
        main_d = accept ? in_data : main_q;
      end
      2'd1: begin
        occ_d  = accept ? (emit ? 2'd1 : 2'd2) : (emit ? 2'd0 : 2'd1);
        main_d = (accept & emit) ? in_data : main_q;
        skid_d = (accept & !emit) ? in_data : skid_q;
      end
      default: begin
        occ_d  = emit ? 2'd1 : 2'd2;
        main_d = emit ? skid_q : main_q;
      end
    endcase
    if (flush) begin
      occ_d  = 2'd0;
      main_d = main_q;
      skid_d = skid_q;
    end
  end
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) skid_q <= '0;
    else          skid_q <= skid_d;
  end
`else
  assign in_ready = !out_valid | out_ready;
  // With no skid slot, accept while full implies emit, so one entry is the ceiling.
  always_comb begin
    occ_d  = flush ? 2'd0 : {1'b0, accept | (occ_q[0] & !emit)};
    main_d = (accept & !flush) ? in_data : main_q;
  end
`endif
  always_ff @(negedge clock or negedge reset_n) begin
    if (!reset_n) begin
      occ_q  <= 2'd0;
      main_q <= '0;
    end else begin
      occ_q  <= occ_d;
      main_q <= main_d;
    end
  end
endmodule
